median_sort_scheduler: RTL and testbench

MEDIAN_SORT_SCHEDULER -- requirements
Module: median_sort_scheduler

---
 rtl/median_sort_scheduler_if.sv | 37 +++
 rtl/median_sort_scheduler.sv | 105 ++++++++++
 tb/tb_median_sort_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_sort_scheduler_if.sv
// Requester, sort-unit and result channels of the median sort scheduler.
// The slave modport is the scheduler side; master is the environment side.
interface median_sort_scheduler_if #(
  parameter int unsigned BIT_WIDTH = 8
);
  localparam int unsigned WIN_W = 9 * BIT_WIDTH;

  logic                 req0_valid_i;
  logic                 req1_valid_i;
  logic [WIN_W-1:0]     req0_win_i;
  logic [WIN_W-1:0]     req1_win_i;
  logic                 req0_ready_o;
  logic                 req1_ready_o;
  logic                 sort_start_o;
  logic [WIN_W-1:0]     sort_win_o;
  logic                 sort_valid_i;
  logic [BIT_WIDTH-1:0] sort_median_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [BIT_WIDTH-1:0] res_data_o;
  logic                 res_src_o;
  logic                 err_timeout_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_win_i, req1_win_i,
    input  sort_valid_i, sort_median_i, res_ready_i,
    output req0_ready_o, req1_ready_o, sort_start_o, sort_win_o,
    output res_valid_o, res_data_o, res_src_o, err_timeout_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_win_i, req1_win_i,
    output sort_valid_i, sort_median_i, res_ready_i,
    input  req0_ready_o, req1_ready_o, sort_start_o, sort_win_o,
    input  res_valid_o, res_data_o, res_src_o, err_timeout_o
  );
endinterface

// File: rtl/median_sort_scheduler.sv
// Round-robin scheduler feeding 3x3 windows from two requesters into a shared
// 9-input sort unit, with sorter timeout and a registered median result port.
module median_sort_scheduler #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                    CLK,
  input logic                    RST,
  median_sort_scheduler_if.slave bus
);
  localparam int unsigned WIN_W = 9 * BIT_WIDTH;
  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN, OUTPUT} state_t;

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 drop;
  logic                 last_grant;
  logic                 src;
  logic                 start;
  logic                 res_valid;
  logic                 err;
  logic [WIN_W-1:0]     win;
  logic [BIT_WIDTH-1:0] res_data;
  logic                 grant0;
  logic                 grant1;

  // Round-robin: on contention the requester that was not granted last wins.
  always_comb begin
    grant0 = bus.req0_valid_i && (!bus.req1_valid_i || last_grant);
    grant1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_grant);
  end

  // Ready is combinational so an accept can happen on the first edge after reset.
  assign bus.req0_ready_o = (state == IDLE) && !RST && grant0;
  assign bus.req1_ready_o = (state == IDLE) && !RST && grant1;

  assign bus.sort_start_o  = start;
  assign bus.sort_win_o    = win;
  assign bus.res_valid_o   = res_valid;
  assign bus.res_data_o    = res_data;
  assign bus.res_src_o     = src;
  assign bus.err_timeout_o = err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      drop       <= 1'b0;
      last_grant <= 1'b1;
      src        <= 1'b0;
      start      <= 1'b0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
      win        <= '0;
      res_data   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          // Stale sorter valid is deliberately not looked at here.
          if (grant0 || grant1) begin
            win        <= grant1 ? bus.req1_win_i : bus.req0_win_i;
            src        <= grant1;
            last_grant <= grant1;
            wait_cnt   <= '0;
            drop       <= 1'b0;
            start      <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (bus.sort_valid_i) begin
            res_data <= bus.sort_median_i;
            start    <= 1'b0;
            state    <= DRAIN;
          end else if (wait_cnt == CNT_LAST) begin
            err   <= 1'b1;
            drop  <= 1'b1;
            start <= 1'b0;
            state <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          // Wait for the sorter to release its done flag before reusing it.
          if (!bus.sort_valid_i) begin
            res_valid <= !drop;
            state     <= drop ? IDLE : OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.res_ready_i) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_sort_scheduler.sv
// Self-checking bench for median_sort_scheduler: directed table, corner
// sequences and random transactions against a behavioural sorter and model.
module tb_median_sort_scheduler;
  localparam int unsigned BW  = 8;
  localparam int unsigned WW  = 9 * BW;
  localparam int          TMO = 64;

  logic CLK = 1'b0;
  logic RST;

  median_sort_scheduler_if #(.BIT_WIDTH(BW)) bus ();

  median_sort_scheduler #(.BIT_WIDTH(BW), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit tb_last;
  int sorter_lat = 1;
  int extra_hold = 0;
  bit sorter_en  = 1'b1;
  bit stale      = 1'b0;

  typedef struct {
    bit            v0;
    bit            v1;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    int            lat;
    int            hold;
    int            rdy;
    bit            exp_src;
    int            exp_med;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_median(input logic [WW-1:0] w);
    int a[9];
    int t;
    for (int k = 0; k < 9; k++) a[k] = int'(w[k*BW +: BW]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  function automatic logic [WW-1:0] mk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*BW +: BW] = 8'($urandom);
    return w;
  endfunction

  // Behavioural sort unit: done after sorter_lat cycles of start, holds done
  // until start drops plus extra_hold cycles.
  initial begin
    logic          s;
    logic [WW-1:0] w;
    int            cnt;
    int            hold_left;
    bus.sort_valid_i  = 1'b0;
    bus.sort_median_i = '0;
    cnt = 0;
    hold_left = 0;
    forever begin
      @(posedge CLK);
      s = bus.sort_start_o;
      w = bus.sort_win_o;
      #1;
      if (RST) begin
        cnt = 0;
        hold_left = 0;
        bus.sort_valid_i = 1'b0;
      end else if (s) begin
        if (!bus.sort_valid_i) begin
          cnt++;
          if (sorter_en && cnt >= sorter_lat) begin
            bus.sort_valid_i  = 1'b1;
            bus.sort_median_i = 8'(ref_median(w));
            hold_left = extra_hold;
          end
        end
      end else begin
        cnt = 0;
        if (stale) bus.sort_valid_i = 1'b1;
        else if (bus.sort_valid_i && hold_left > 0) hold_left--;
        else bus.sort_valid_i = 1'b0;
      end
    end
  end

  task automatic run_txn(input bit v0, input bit v1, input logic [WW-1:0] w0,
                         input logic [WW-1:0] w1, input int lat, input int hold,
                         input int rdy_dly, input bit exp_src, input int exp_med,
                         input string nm);
    bit            got;
    bit            ok;
    int            k;
    logic [BW-1:0] d0;
    sorter_lat = lat;
    extra_hold = hold;
    @(posedge CLK); #1;
    bus.req0_valid_i = v0;
    bus.req1_valid_i = v1;
    bus.req0_win_i   = w0;
    bus.req1_win_i   = w1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (bus.req0_ready_o || bus.req1_ready_o) begin
        got = 1'b1;
        chk({nm, " grant"}, WW'({bus.req1_ready_o, bus.req0_ready_o}),
            exp_src ? WW'(2) : WW'(1));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s grant: no ready within 20 cycles", nm);
      bus.req0_valid_i = 1'b0;
      bus.req1_valid_i = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    got = 1'b0; ok = 1'b1; k = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge CLK);
      if (bus.err_timeout_o) ok = 1'b0;
      if (bus.res_valid_o) got = 1'b1;
      else k++;
    end
    chk({nm, " no_timeout"}, WW'(ok), WW'(1));
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s result: res_valid not seen within 300 cycles", nm);
      return;
    end
    chk({nm, " latency"}, WW'(k), WW'(lat + 3 + hold));
    chk({nm, " data"}, WW'(bus.res_data_o), WW'(exp_med));
    chk({nm, " src"}, WW'(bus.res_src_o), WW'(exp_src));
    chk({nm, " sort_win"}, bus.sort_win_o, exp_src ? w1 : w0);
    d0 = bus.res_data_o;
    if (rdy_dly > 0) begin
      bus.req0_valid_i = 1'b1;
      bus.req1_valid_i = 1'b1;
      ok = 1'b1;
      repeat (rdy_dly) begin
        @(negedge CLK);
        if (!bus.res_valid_o || bus.res_data_o !== d0 || bus.res_src_o !== exp_src ||
            bus.req0_ready_o || bus.req1_ready_o) ok = 1'b0;
      end
      chk({nm, " hold_stable"}, WW'(ok), WW'(1));
      bus.req0_valid_i = 1'b0;
      bus.req1_valid_i = 1'b0;
    end
    bus.res_ready_i = 1'b1;
    @(posedge CLK); #1;
    bus.res_ready_i = 1'b0;
    @(negedge CLK);
    chk({nm, " one_beat"}, WW'(bus.res_valid_o), WW'(0));
  endtask

  initial begin
    bit            got;
    bit            ok;
    bit            both;
    int            first;
    int            pulses;
    int            n;
    bit            rv;
    int            pat;
    bit            es;
    logic [WW-1:0] wa;
    logic [WW-1:0] wb;
    logic [BW-1:0] srcs[4];
    logic [BW-1:0] meds[4];

    RST = 1'b1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.req0_win_i   = '1;
    bus.req1_win_i   = '1;
    bus.res_ready_i  = 1'b0;
    #2;
    chk("reset ready", WW'({bus.req1_ready_o, bus.req0_ready_o}), WW'(0));
    chk("reset sort_start", WW'(bus.sort_start_o), WW'(0));
    chk("reset res_valid", WW'(bus.res_valid_o), WW'(0));
    chk("reset err", WW'(bus.err_timeout_o), WW'(0));
    chk("reset res_data", WW'(bus.res_data_o), WW'(0));
    chk("reset sort_win", bus.sort_win_o, WW'(0));
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    @(posedge CLK); @(posedge CLK); #3;
    RST = 1'b0;
    tb_last = 1'b1;

    vecs[0] = '{1'b1, 1'b0, mk(9,8,7,6,5,4,3,2,1), '0, 1, 0, 0, 1'b0, 5};
    vecs[1] = '{1'b1, 1'b1, mk(1,1,1,1,1,1,1,1,1), mk(10,20,30,40,50,60,70,80,90), 2, 0, 0, 1'b1, 50};
    vecs[2] = '{1'b1, 1'b1, mk(200,3,255,0,17,17,99,4,128), mk(7,7,7,7,7,7,7,7,7), 3, 2, 10, 1'b0, 17};
    vecs[3] = '{1'b0, 1'b1, '0, mk(255,255,255,255,255,255,255,255,255), 1, 0, 0, 1'b1, 255};
    vecs[4] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0), mk(1,2,3,4,5,6,7,8,9), 5, 1, 2, 1'b0, 0};
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].v0, vecs[i].v1, vecs[i].w0, vecs[i].w1, vecs[i].lat, vecs[i].hold,
              vecs[i].rdy, vecs[i].exp_src, vecs[i].exp_med, $sformatf("vec%0d", i));
      tb_last = vecs[i].exp_src;
    end

    // Stale sorter done while idle must not produce anything.
    stale = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (bus.res_valid_o || bus.sort_start_o || bus.err_timeout_o) ok = 1'b0;
    end
    stale = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stale ignored", WW'(ok), WW'(1));

    // Sorter never answers: single timeout pulse, no result, then recovery.
    sorter_en = 1'b0;
    @(posedge CLK); #1;
    bus.req0_valid_i = 1'b1;
    bus.req0_win_i   = rand_win();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (bus.req0_ready_o) got = 1'b1;
    end
    chk("timeout accept", WW'(got), WW'(1));
    @(posedge CLK); #1;
    bus.req0_valid_i = 1'b0;
    tb_last = 1'b0;
    first = -1; pulses = 0; rv = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.err_timeout_o) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (bus.res_valid_o) rv = 1'b1;
    end
    chk("timeout delay", WW'(first), WW'(TMO));
    chk("timeout pulses", WW'(pulses), WW'(1));
    chk("timeout no_result", WW'(rv), WW'(0));
    sorter_en = 1'b1;
    wa = rand_win();
    wb = rand_win();
    run_txn(1'b1, 1'b1, wa, wb, 2, 0, 0, 1'b1, ref_median(wb), "after_timeout");
    tb_last = 1'b1;

    // Asynchronous reset in the middle of a launch.
    sorter_lat = 30;
    @(posedge CLK); #1;
    bus.req1_valid_i = 1'b1;
    bus.req1_win_i   = rand_win();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (bus.req1_ready_o) got = 1'b1;
    end
    chk("rst_mid accept", WW'(got), WW'(1));
    @(posedge CLK); #1;
    bus.req1_valid_i = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst_mid sort_start", WW'(bus.sort_start_o), WW'(0));
    chk("rst_mid res_src", WW'(bus.res_src_o), WW'(0));
    chk("rst_mid ready", WW'({bus.req1_ready_o, bus.req0_ready_o}), WW'(0));
    chk("rst_mid sort_win", bus.sort_win_o, WW'(0));
    chk("rst_mid res_valid_err", WW'({bus.res_valid_o, bus.err_timeout_o}), WW'(0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tb_last = 1'b1;
    #1;
    chk("rst_release ready", WW'({bus.req1_ready_o, bus.req0_ready_o}), WW'(1));
    #1;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    wa = rand_win();
    wb = rand_win();
    run_txn(1'b1, 1'b1, wa, wb, 1, 0, 0, 1'b0, ref_median(wa), "after_reset");
    tb_last = 1'b0;

    // Both requesters continuously valid from reset: sources alternate 0,1,0,1.
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #3;
    RST = 1'b0;
    tb_last = 1'b1;
    sorter_lat = 1;
    extra_hold = 0;
    wa = rand_win();
    wb = rand_win();
    bus.req0_win_i  = wa;
    bus.req1_win_i  = wb;
    bus.res_ready_i = 1'b1;
    @(posedge CLK); #1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    n = 0; both = 1'b0;
    for (int c = 0; c < 400 && n < 4; c++) begin
      @(negedge CLK);
      if (bus.req0_ready_o && bus.req1_ready_o) both = 1'b1;
      if (bus.res_valid_o) begin
        srcs[n] = BW'(bus.res_src_o);
        meds[n] = bus.res_data_o;
        n++;
      end
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    @(posedge CLK); #1;
    bus.res_ready_i = 1'b0;
    chk("rr both_ready", WW'(both), WW'(0));
    chk("rr count", WW'(n), WW'(4));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr src%0d", i), WW'(srcs[i]), WW'(i % 2));
      chk($sformatf("rr data%0d", i), WW'(meds[i]),
          WW'(ref_median((i % 2) != 0 ? wb : wa)));
    end
    tb_last = 1'b1;

    // Random transactions against the reference model.
    for (int i = 0; i < 25; i++) begin
      pat = int'($urandom_range(1, 3));
      wa  = rand_win();
      wb  = rand_win();
      if (pat == 3) es = !tb_last;
      else es = (pat == 2);
      run_txn(pat[0], pat[1], wa, wb, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), es, ref_median(es ? wb : wa), $sformatf("rnd%0d", i));
      tb_last = es;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
